// File: rtl/game_master_pkg.sv
// Shared types and sizing helpers for the game controller stages.
package game_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    AIM   = 3'd2,
    SHOT  = 3'd3,
    END   = 3'd4
  } state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned END_CYCLES_DEFAULT = 50_000_000;
  localparam int unsigned PAUSE_W_DEFAULT    = cnt_width(END_CYCLES_DEFAULT);

endpackage

// File: rtl/game_rise_edge.sv
// Rising-edge detector for a debounced key level, with synchronous reset.
module game_rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level;
  end

  // The history bit tracks the key even while reset is held, so a key
  // held down across reset release is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    level_q <= level_d;
  end

  always_comb begin
    rise = level & ~level_q & ~reset;
  end

endmodule

// File: rtl/game_master_fsm.sv
// Round sequencer: spawns target and torpedo, scores hits, pauses, restarts.
module game_master_fsm
  import game_master_pkg::*;
#(
  parameter int unsigned END_CYCLES   = 50_000_000,
  parameter int unsigned SCORE_WIDTH  = 8,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   launch_key,
  input  logic                   collision,
  input  logic                   target_out_of_screen,
  input  logic                   torpedo_out_of_screen,
  output logic                   target_sprite_enable,
  output logic                   target_write_xy,
  output logic                   torpedo_sprite_enable,
  output logic                   torpedo_write_xy,
  output logic                   end_of_game,
  output logic                   game_won,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam int unsigned PAUSE_W = cnt_width(END_CYCLES);
  localparam int unsigned GUARD_W = cnt_width(GUARD_CYCLES + 1);

  localparam logic [PAUSE_W-1:0]     PAUSE_LAST = PAUSE_W'(END_CYCLES - 1);
  localparam logic [GUARD_W-1:0]     GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};

  logic launch_edge;

  state_t                 state_q, state_d;
  logic [GUARD_W-1:0]     guard_q, guard_d;
  logic [PAUSE_W-1:0]     pause_q, pause_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   won_q,   won_d;
  logic                   hit;

  game_rise_edge u_launch_edge (
    .clk   (clk),
    .reset (reset),
    .level (launch_key),
    .rise  (launch_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      guard_q <= '0;
      pause_q <= '0;
      score_q <= '0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      pause_q <= pause_d;
      score_q <= score_d;
      won_q   <= won_d;
    end
  end

  // The overlap flag lags the sprite positions, so it is only trusted once
  // the guard window after the torpedo spawn has fully elapsed.
  always_comb begin
    hit = collision && (guard_q == '0);
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    pause_d = pause_q;
    score_d = score_q;
    won_d   = won_q;
    case (state_q)
      IDLE: begin
        if (launch_edge) state_d = SPAWN;
      end
      SPAWN: begin
        state_d = AIM;
        won_d   = 1'b0;
      end
      AIM: begin
        if (target_out_of_screen) begin
          state_d = END;
          won_d   = 1'b0;
          pause_d = '0;
        end else if (launch_edge) begin
          state_d = SHOT;
          guard_d = GUARD_LOAD;
        end
      end
      SHOT: begin
        if (guard_q != '0) guard_d = guard_q - GUARD_W'(1);
        if (hit) begin
          state_d = END;
          won_d   = 1'b1;
          pause_d = '0;
          score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_WIDTH'(1);
        end else if (target_out_of_screen) begin
          state_d = END;
          won_d   = 1'b0;
          pause_d = '0;
        end else if (torpedo_out_of_screen) begin
          state_d = AIM;
        end
      end
      END: begin
        if (pause_q == PAUSE_LAST) begin
          state_d = SPAWN;
          pause_d = '0;
          if (!won_q) score_d = '0;
        end else begin
          pause_d = pause_q + PAUSE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Torpedo load pulse is the first SHOT cycle, recognisable by a full guard.
  always_comb begin
    target_sprite_enable  = 1'b0;
    target_write_xy       = 1'b0;
    torpedo_sprite_enable = 1'b0;
    torpedo_write_xy      = 1'b0;
    end_of_game           = 1'b0;
    game_won              = won_q;
    score                 = score_q;
    case (state_q)
      SPAWN: target_write_xy = 1'b1;
      AIM:   target_sprite_enable = 1'b1;
      SHOT: begin
        target_sprite_enable  = 1'b1;
        torpedo_sprite_enable = 1'b1;
        torpedo_write_xy      = (guard_q == GUARD_LOAD);
      end
      END:     end_of_game = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_master_fsm.sv
// Directed bench with a cycle-level behavioural model of round sequencing.
module tb_game_master_fsm;

  localparam int END_CYCLES   = 8;
  localparam int SCORE_WIDTH  = 4;
  localparam int GUARD_CYCLES = 2;
  localparam int SCORE_MAX    = (1 << SCORE_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset, launch_key, collision, target_oos, torpedo_oos;
  logic target_en, target_wr, torpedo_en, torpedo_wr, eog, won;
  logic [SCORE_WIDTH-1:0] score;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase names plus ages/countdowns rather than the RTL's counters.
  localparam int P_IDLE = 0, P_SPAWN = 1, P_AIM = 2, P_SHOT = 3, P_END = 4;
  int m_phase     = P_IDLE;
  int m_shot_age  = 0;
  int m_pause_rem = 0;
  int m_score     = 0;
  bit m_won       = 0;
  bit m_prev_key  = 0;

  always #5 clk = ~clk;

  game_master_fsm #(
    .END_CYCLES   (END_CYCLES),
    .SCORE_WIDTH  (SCORE_WIDTH),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .launch_key            (launch_key),
    .collision             (collision),
    .target_out_of_screen  (target_oos),
    .torpedo_out_of_screen (torpedo_oos),
    .target_sprite_enable  (target_en),
    .target_write_xy       (target_wr),
    .torpedo_sprite_enable (torpedo_en),
    .torpedo_write_xy      (torpedo_wr),
    .end_of_game           (eog),
    .game_won              (won),
    .score                 (score)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter_end(input bit did_win);
    m_phase     = P_END;
    m_pause_rem = END_CYCLES;
    m_won       = did_win;
    if (did_win && m_score < SCORE_MAX) m_score++;
  endtask

  task automatic model_update();
    bit edge_seen;
    edge_seen  = launch_key && !m_prev_key && !reset;
    m_prev_key = launch_key;
    if (reset) begin
      m_phase = P_IDLE; m_score = 0; m_won = 0; m_shot_age = 0; m_pause_rem = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (edge_seen) m_phase = P_SPAWN;
        P_SPAWN: begin m_phase = P_AIM; m_won = 0; end
        P_AIM: begin
          if (target_oos) enter_end(0);
          else if (edge_seen) begin m_phase = P_SHOT; m_shot_age = 0; end
        end
        P_SHOT: begin
          if (collision && m_shot_age >= GUARD_CYCLES) enter_end(1);
          else if (target_oos) enter_end(0);
          else if (torpedo_oos) m_phase = P_AIM;
          else m_shot_age++;
        end
        default: begin
          m_pause_rem--;
          if (m_pause_rem == 0) begin
            m_phase = P_SPAWN;
            if (!m_won) m_score = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: model advances on the edge, DUT outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("target_sprite_enable", target_en, (m_phase == P_AIM || m_phase == P_SHOT));
    chk("target_write_xy", target_wr, (m_phase == P_SPAWN));
    chk("torpedo_sprite_enable", torpedo_en, (m_phase == P_SHOT));
    chk("torpedo_write_xy", torpedo_wr, (m_phase == P_SHOT && m_shot_age == 0));
    chk("end_of_game", eog, (m_phase == P_END));
    chk("game_won", won, m_won);
    chk("score", score, m_score);
  endtask

  task automatic press();
    launch_key = 1'b1; step();
    launch_key = 1'b0;
  endtask

  // Called with END already observed; returns with the SPAWN cycle observed.
  task automatic run_end(output int len);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!eog) break;
      len++;
    end
  endtask

  // Called with SPAWN observed: aim, shoot, wait out the guard, hit, pause.
  task automatic play_hit();
    int len;
    step();
    press();
    step(); step();
    collision = 1'b1; step();
    collision = 1'b0;
    run_end(len);
    $display("round hit: score=%0d pause=%0d", score, len);
  endtask

  initial begin
    int len;
    reset = 1'b1; launch_key = 1'b1; collision = 1'b0;
    target_oos = 1'b0; torpedo_oos = 1'b0;
    repeat (3) step();
    chk("reset_score", score, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("held_key_idle_wr", target_wr, 0);
    chk("held_key_idle_en", target_en, 0);

    launch_key = 1'b0; step();
    press();
    chk("spawn_pulse", target_wr, 1);
    step();
    chk("aim_enable", target_en, 1);
    chk("aim_pulse_gone", target_wr, 0);

    press();
    chk("torpedo_pulse", torpedo_wr, 1);
    collision = 1'b1;
    step();
    chk("torpedo_pulse_one_cycle", torpedo_wr, 0);
    step();
    chk("guard_ignores_collision", eog, 0);
    step();
    collision = 1'b0;
    chk("hit_won", won, 1);
    chk("hit_score", score, 1);
    run_end(len);
    chk("pause_len", len, END_CYCLES);
    chk("restart_pulse", target_wr, 1);
    $display("round 1: score=%0d pause=%0d", score, len);

    step();
    press();
    torpedo_oos = 1'b1; step();
    torpedo_oos = 1'b0;
    chk("miss_torpedo_off", torpedo_en, 0);
    chk("miss_score_hold", score, 1);
    press();
    chk("reshoot_pulse", torpedo_wr, 1);
    step(); step();
    collision = 1'b1; torpedo_oos = 1'b1; step();
    collision = 1'b0; torpedo_oos = 1'b0;
    chk("tie_hit_wins", score, 2);
    run_end(len);
    $display("round 2: score=%0d pause=%0d", score, len);

    repeat (14) play_hit();
    chk("score_saturated", score, SCORE_MAX);

    step();
    target_oos = 1'b1; step();
    target_oos = 1'b0;
    chk("lost_won", won, 0);
    chk("lost_score_held", score, SCORE_MAX);
    run_end(len);
    chk("lost_score_cleared", score, 0);
    $display("round lost: score=%0d pause=%0d", score, len);

    step();
    press();
    step(); step();
    collision = 1'b1; step();
    collision = 1'b0;
    chk("pre_reset_score", score, 1);
    repeat (3) step();
    reset = 1'b1; step();
    reset = 1'b0;
    chk("reset_mid_end_eog", eog, 0);
    chk("reset_mid_end_score", score, 0);
    repeat (12) step();
    chk("no_auto_restart", target_wr, 0);
    $display("reset in pause: score=%0d eog=%0d", score, eog);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
